// File: rtl/smash_noc_pkg.sv
// Shared NoC router definitions: default port count, flit framing and the
// output-port arbiter state type.
package smash_noc_pkg;

    localparam int SMASH_NUM_PORTS = 4;
    localparam int SMASH_DATA_SIZE = 32;

    // Tail flag position for the default flit width (MSB of the flit).
    localparam int FLIT_TAIL = SMASH_DATA_SIZE - 1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/smash_rr_pick.sv
// Combinational round-robin picker shared by the router output ports.
// Rotates the request vector so that the entry after ptr_i sits at bit 0,
// takes the lowest set bit, then rotates the winner index back.
module smash_rr_pick #(
    parameter int NUM_IN = 4,
    parameter int PTR_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] pick_o,
    output logic [PTR_W-1:0]  pick_idx_o
);

    logic [2*NUM_IN-1:0] req_dbl;
    logic [NUM_IN-1:0]   req_rot;
    logic [PTR_W:0]      shift;
    logic                found;
    int                  rot_idx;
    int                  abs_idx;

    // Rotate, priority-encode from bit 0, rotate back
    always_comb begin
        shift      = {1'b0, ptr_i} + 1'b1;
        req_dbl    = {req_i, req_i};
        req_rot    = req_dbl[shift +: NUM_IN];
        found      = 1'b0;
        rot_idx    = 0;
        abs_idx    = 0;
        pick_o     = '0;
        pick_idx_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                rot_idx = i;
            end
        end
        if (found) begin
            abs_idx = rot_idx + int'(shift);
            if (abs_idx >= NUM_IN) begin
                abs_idx = abs_idx - NUM_IN;
            end
            pick_idx_o         = PTR_W'(abs_idx);
            pick_o[pick_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/smash_port_arbiter.sv
// Wormhole round-robin arbiter for one router output port. An input that wins
// arbitration owns the link until its tail flit has been accepted downstream.
// Optional stall release is built when SMASH_ARB_TIMEOUT_EN is defined.
module smash_port_arbiter
    import smash_noc_pkg::*;
#(
    parameter int NUM_IN         = SMASH_NUM_PORTS,
    parameter int DATA_SIZE      = SMASH_DATA_SIZE,
    parameter int PTR_W          = $clog2(NUM_IN),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_IN-1:0]           i_empty,
    input  logic [NUM_IN*DATA_SIZE-1:0] i_data,
    output logic [NUM_IN-1:0]           o_read,
    output logic [DATA_SIZE-1:0]        o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [NUM_IN-1:0]           o_grant,
    output logic                        o_busy,
    output logic                        o_timeout
);

    // Equals FLIT_TAIL at the default flit width.
    localparam int TAIL_BIT = DATA_SIZE - 1;

    arb_state_t           state_q, state_d;
    logic [NUM_IN-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]     grant_idx_q, grant_idx_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_IN-1:0]    req;
    logic [NUM_IN-1:0]    pick_oh;
    logic [PTR_W-1:0]     pick_idx;
    logic [DATA_SIZE-1:0] head;
    logic                 locked;
    logic                 xfer;
    logic                 stall_expire;

    assign req    = ~i_empty;
    assign locked = (state_q == ARB_LOCKED);
    assign head   = i_data[grant_idx_q*DATA_SIZE +: DATA_SIZE];

    assign o_valid = locked & ~i_empty[grant_idx_q];
    assign xfer    = o_valid & i_ready;
    assign o_read  = xfer ? grant_q : '0;
    assign o_data  = locked ? head : '0;
    assign o_grant = grant_q;
    assign o_busy  = locked;

    smash_rr_pick #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req_i      (req),
        .ptr_i      (rr_ptr_q),
        .pick_o     (pick_oh),
        .pick_idx_o (pick_idx)
    );

`ifdef SMASH_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_q;

    // Count locked cycles without a transfer; expire when the limit is hit
    always_comb begin
        stall_d      = '0;
        stall_expire = 1'b0;
        if (locked && !xfer) begin
            stall_d = stall_q + 1'b1;
            if (stall_d == STALL_W'(TIMEOUT_CYCLES)) begin
                stall_expire = 1'b1;
                stall_d      = '0;
            end
        end
    end

    // Stall counter and one-cycle release pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= stall_expire;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign stall_expire = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    // Grant on any request in IDLE; release on tail transfer or stall expiry
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d     = ARB_LOCKED;
                    grant_d     = pick_oh;
                    grant_idx_d = pick_idx;
                end
            end
            ARB_LOCKED: begin
                if ((xfer && head[TAIL_BIT]) || stall_expire) begin
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = grant_idx_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter state, owner and round-robin pointer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= PTR_W'(NUM_IN - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_smash_port_arbiter.sv
// Bench for smash_port_arbiter: bench-side FIFOs as queues, a packet-level
// reference model, directed scenarios with literal expectations and a
// randomized traffic phase. Timeout scenario is built with SMASH_ARB_TIMEOUT_EN.
module tb_smash_port_arbiter;

    localparam int NUM_IN = 4;
    localparam int DS     = 32;
    localparam int TO     = 8;

    logic                   i_clk = 1'b0;
    logic                   i_rst = 1'b1;
    logic [NUM_IN-1:0]      i_empty = '1;
    logic [NUM_IN*DS-1:0]   i_data = '0;
    logic                   i_ready = 1'b0;
    logic [NUM_IN-1:0]      o_read;
    logic [DS-1:0]          o_data;
    logic                   o_valid;
    logic [NUM_IN-1:0]      o_grant;
    logic                   o_busy;
    logic                   o_timeout;

    smash_port_arbiter #(
        .NUM_IN         (NUM_IN),
        .DATA_SIZE      (DS),
        .PTR_W          (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_empty   (i_empty),
        .i_data    (i_data),
        .o_read    (o_read),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Input FIFO contents and per-input staging of not-yet-written flits
    logic [DS-1:0] fq [NUM_IN][$];
    logic [DS-1:0] sq [NUM_IN][$];

    // Packet-level model: owner (-1 idle), previous owner, stall count
    int m_owner = -1;
    int m_last  = NUM_IN - 1;
    int m_stall = 0;
    bit m_to    = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic [3:0]  g2 [9] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    logic [31:0] d2 [9] = '{32'h0, 32'h0000_A000, 32'h0000_A001, 32'h8000_A002, 32'h0,
                            32'h0000_B000, 32'h0000_B001, 32'h8000_B002, 32'h0};
    logic [3:0]  g3 [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive_fifos();
        for (int k = 0; k < NUM_IN; k++) begin
            i_empty[k] = (fq[k].size() == 0);
            i_data[k*DS +: DS] = (fq[k].size() != 0) ? fq[k][0] : (32'hDEAD_0000 | k);
        end
    endtask

    // Advance to the next falling edge, trickle staged flits in, drive FIFOs
    task automatic step();
        @(negedge i_clk);
        for (int k = 0; k < NUM_IN; k++) begin
            if (sq[k].size() != 0 && $urandom_range(0, 9) < 6)
                fq[k].push_back(sq[k].pop_front());
        end
        drive_fifos();
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        for (int k = 0; k < NUM_IN; k++) sq[k].delete();
        repeat (n) step();
        i_rst = 1'b0;
    endtask

    // Reference model advances on every rising edge
    initial begin : model
        logic [DS-1:0] f;
        int k;
        forever begin
            @(posedge i_clk);
            if (i_rst) begin
                m_owner = -1;
                m_last  = NUM_IN - 1;
                m_stall = 0;
                m_to    = 1'b0;
                for (int j = 0; j < NUM_IN; j++) fq[j].delete();
            end else begin
                m_to = 1'b0;
                if (m_owner < 0) begin
                    for (int i = 1; i <= NUM_IN; i++) begin
                        k = (m_last + i) % NUM_IN;
                        if (fq[k].size() != 0) begin
                            m_owner = k;
                            break;
                        end
                    end
                    m_stall = 0;
                end else if (fq[m_owner].size() != 0 && i_ready) begin
                    f = fq[m_owner].pop_front();
                    m_stall = 0;
                    if (f[DS-1]) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end else begin
`ifdef SMASH_ARB_TIMEOUT_EN
                    m_stall++;
                    if (m_stall == TO) begin
                        m_last  = m_owner;
                        m_owner = -1;
                        m_stall = 0;
                        m_to    = 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    initial begin : compare
        logic [NUM_IN-1:0] eg, er;
        logic              ev;
        logic [DS-1:0]     ed;
        forever begin
            @(negedge i_clk);
            #2;
            if (chk_en && !i_rst) begin
                if (m_owner < 0) begin
                    eg = '0; ev = 1'b0; ed = '0;
                end else begin
                    eg = NUM_IN'(1) << m_owner;
                    ev = (fq[m_owner].size() != 0);
                    ed = ev ? fq[m_owner][0] : '0;
                end
                er = (ev && i_ready) ? eg : '0;
                chk("grant", 32'(o_grant), 32'(eg));
                chk("valid", 32'(o_valid), 32'(ev));
                chk("read", 32'(o_read), 32'(er));
                chk("busy", 32'(o_busy), 32'(m_owner >= 0));
                chk("timeout", 32'(o_timeout), 32'(m_to));
                if (m_owner < 0 || ev) chk("data", o_data, ed);
            end
        end
    end

    initial begin : stim
        int k, len;
        do_reset(2);
        chk_en = 1'b1;

        // All inputs empty: nothing granted, read or valid
        i_ready = 1'b1;
        repeat (10) begin
            step(); #3;
            chk("t1_grant", 32'(o_grant), 32'h0);
            chk("t1_valid", 32'(o_valid), 32'h0);
            chk("t1_read", 32'(o_read), 32'h0);
        end

        // Two 3-flit packets on inputs 0 and 2
        step();
        fq[0].push_back(32'h0000_A000); fq[0].push_back(32'h0000_A001); fq[0].push_back(32'h8000_A002);
        fq[2].push_back(32'h0000_B000); fq[2].push_back(32'h0000_B001); fq[2].push_back(32'h8000_B002);
        drive_fifos();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) step();
            #3;
            chk("t2_grant", 32'(o_grant), 32'(g2[c]));
            chk("t2_read", 32'(o_read), 32'(g2[c]));
            chk("t2_data", o_data, d2[c]);
        end

        // Single-flit packets on all inputs: round-robin order with a bubble
        do_reset(1);
        for (int p = 0; p < 3; p++)
            for (int j = 0; j < NUM_IN; j++) fq[j].push_back(32'h8000_0000 | (j << 8) | p);
        drive_fifos();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) step();
            #3;
            chk("t3_grant", 32'(o_grant), 32'(g3[c]));
            chk("t3_read", 32'(o_read), 32'(g3[c]));
        end

        // Backpressure mid-packet on input 1
        do_reset(1);
        fq[1].push_back(32'h0000_C000); fq[1].push_back(32'h0000_C001); fq[1].push_back(32'h8000_C002);
        drive_fifos();
        step(); #3;
        chk("t4_first", o_data, 32'h0000_C000);
        chk("t4_first_read", 32'(o_read), 32'h2);
        for (int c = 0; c < 5; c++) begin
            step(); i_ready = 1'b0; #3;
            chk("t4_hold_valid", 32'(o_valid), 32'h1);
            chk("t4_hold_data", o_data, 32'h0000_C001);
            chk("t4_hold_read", 32'(o_read), 32'h0);
        end
        step(); i_ready = 1'b1; #3;
        chk("t4_resume", o_data, 32'h0000_C001);
        chk("t4_resume_read", 32'(o_read), 32'h2);
        step(); #3;
        chk("t4_tail", o_data, 32'h8000_C002);
        step(); #3;
        chk("t4_release", 32'(o_grant), 32'h0);

        // Owner runs dry mid-packet while input 3 waits
        do_reset(1);
        fq[1].push_back(32'h0000_D000);
        fq[3].push_back(32'h0000_E000); fq[3].push_back(32'h8000_E001);
        drive_fifos();
        step(); #3;
        chk("t5_head", o_data, 32'h0000_D000);
        for (int c = 0; c < 3; c++) begin
            step(); #3;
            chk("t5_hold_grant", 32'(o_grant), 32'h2);
            chk("t5_hold_valid", 32'(o_valid), 32'h0);
        end
        step();
        fq[1].push_back(32'h8000_D001);
        drive_fifos();
        #3;
        chk("t5_tail", o_data, 32'h8000_D001);
        chk("t5_tail_read", 32'(o_read), 32'h2);
        step(); #3;
        chk("t5_bubble", 32'(o_grant), 32'h0);
        step(); #3;
        chk("t5_next_grant", 32'(o_grant), 32'h8);
        chk("t5_next_data", o_data, 32'h0000_E000);
        repeat (3) step();

`ifdef SMASH_ARB_TIMEOUT_EN
        // Owner stalls forever: forced release, owner drops to lowest priority
        do_reset(1);
        fq[1].push_back(32'h0000_F000);
        drive_fifos();
        step(); #3;
        chk("t6_head", 32'(o_read), 32'h2);
        step();
        fq[0].push_back(32'h8000_0A00);
        fq[2].push_back(32'h8000_0B00);
        drive_fifos();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            #3;
            chk("t6_stall_grant", 32'(o_grant), 32'h2);
            chk("t6_stall_to", 32'(o_timeout), 32'h0);
        end
        step(); #3;
        chk("t6_pulse", 32'(o_timeout), 32'h1);
        chk("t6_idle", 32'(o_busy), 32'h0);
        step(); #3;
        chk("t6_regrant", 32'(o_grant), 32'h4);
        chk("t6_pulse_end", 32'(o_timeout), 32'h0);
        step(); step(); #3;
        chk("t6_last", 32'(o_grant), 32'h1);
        repeat (3) step();
`endif

        // Randomized traffic with trickling FIFOs, backpressure and resets
        do_reset(1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            i_rst   = 1'b0;
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 10) begin
                k = $urandom_range(0, NUM_IN - 1);
                if (sq[k].size() == 0 && fq[k].size() < 6) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++)
                        sq[k].push_back(($urandom() & 32'h7FFF_FFFF) | ((j == len - 1) ? 32'h8000_0000 : 32'h0));
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                i_rst = 1'b1;
                for (int j = 0; j < NUM_IN; j++) sq[j].delete();
            end
        end
        i_rst = 1'b0;
        repeat (4) step();
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/smash_port_arbiter.md
Name: smash_port_arbiter

Overview:
Wormhole round-robin arbiter for one NoC router output port. It shares the output link between NUM_IN input FIFOs, each exposing a combinational head flit, an empty flag and a read strobe. Once granted, an input keeps the port until its tail flit transfers. The arbiter then pops flits from that FIFO toward a downstream ready/valid link.

Parameters:
NUM_IN, 4, number of requesting input FIFOs (2..8)
DATA_SIZE, 32, flit width; bit DATA_SIZE-1 is the tail flag
PTR_W, $clog2(NUM_IN), width of grant index / round-robin pointer
TIMEOUT_CYCLES, 64, stall limit used only with SMASH_ARB_TIMEOUT_EN

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_empty  in  NUM_IN  per-input FIFO empty flag
i_data  in  NUM_IN*DATA_SIZE  per-input head flit; input k at [k*DATA_SIZE +: DATA_SIZE]
o_read  out  NUM_IN  per-input pop strobe, at most one bit high
o_data  out  DATA_SIZE  flit to downstream link
o_valid  out  1  o_data valid
i_ready  in  1  downstream can accept (not full)
o_grant  out  NUM_IN  one-hot current owner, 0 when idle
o_busy  out  1  high in LOCKED
o_timeout  out  1  one-cycle pulse on forced release (0 when feature off)

Behaviour:
- Reset values: state IDLE, rr_ptr=NUM_IN-1, o_grant=0, o_read=0, o_valid=0, o_busy=0, o_timeout=0, o_data=0.
- Request vector: req[k] = !i_empty[k].
- IDLE:
  - If req!=0, pick the first set bit scanning from rr_ptr+1 upward, modulo NUM_IN.
  - Register the pick as grant and go to LOCKED. Arbitration latency is one cycle.
  - No read or valid is issued in IDLE.
- LOCKED (grant index g):
  - o_valid = !i_empty[g]
  - o_data = head flit of g (combinational mux, zero when idle)
  - o_read[g] = o_valid && i_ready
  - A transfer is o_valid && i_ready.
  - A transfer with tail bit 1 moves to IDLE, sets rr_ptr=g and clears o_grant, all on the next edge.
  - A non-tail transfer stays in LOCKED.
  - Empty FIFO mid-packet: hold the grant, o_valid=0, no other input is served.
- Fairness: the most recent owner has lowest priority in the next arbitration.
- Back-to-back packets: after a tail, the next grant is issued in the following IDLE cycle. There is one bubble cycle per packet.
- Single-flit packet (head is also tail): locked for exactly one transfer.
- The tail flag is the only framing; no head/length check is made.
- Simultaneous requests in IDLE: only the winner is granted; the losers' FIFOs are untouched.
- Reset mid-packet: returns to IDLE immediately. The partial packet is abandoned, and the FIFOs are reset by the same i_rst.
- o_read never asserts for a non-granted or empty input.
- o_read is never asserted while i_ready=0.

Optional Feature:
Macro SMASH_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter (width $clog2(TIMEOUT_CYCLES+1)) clears on every transfer and on grant.
  - It increments each LOCKED cycle with no transfer.
  - On reaching TIMEOUT_CYCLES, the arbiter goes to IDLE, sets rr_ptr=g and pulses o_timeout for one cycle. No flit is dropped or popped.
- Undefined: no counter exists, o_timeout is tied to 0, and the grant is held indefinitely.

Decomposition:
- Package smash_noc_pkg holds:
  - tail bit index constant FLIT_TAIL = DATA_SIZE-1
  - state typedef arb_state_t {ARB_IDLE, ARB_LOCKED}
  - default port count constant SMASH_NUM_PORTS = 4
- Sub-module smash_rr_pick: purely combinational rotate-priority-rotate-back picker.
  - Inputs: req[NUM_IN], ptr[PTR_W].
  - Outputs: one-hot pick and pick index.
  - It is reused by other router ports.

Test Plan:
1. Reset, then all inputs empty for 10 cycles -> o_grant=0, o_valid=0, o_read=0 throughout.
2. Inputs 0 and 2 each hold a 3-flit packet (tail on the 3rd), i_ready=1 -> grant input 0 one cycle later. Flits of 0 appear on 3 consecutive cycles, then 1 idle cycle, then input 2's 3 flits. o_read pulses match.
3. All 4 inputs hold single-flit packets continuously, starting after reset -> grant order 0,1,2,3,0,..., each taking 2 cycles (grant + transfer).
4. Input 1 is granted and i_ready drops for 5 cycles mid-packet -> o_valid stays 1, o_data is stable, o_read=0. The transfer resumes when i_ready=1, with no flit lost or duplicated.
5. Input 1 goes empty after its head flit while input 3 requests -> grant stays with 1 and o_valid=0. When 1 refills with its tail, it transfers, and only then is 3 granted.
6. With SMASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the locked input stays empty -> o_timeout pulses after 8 stalled cycles, the state returns to IDLE, and the next request is granted with the stalled input at lowest priority.
